// File: rtl/jtframe_mixgain_pkg.sv
// Shared constants for the mixer gain controller: gain width, unity gain,
// limiter state encoding and the one-LSB ramp step helper.
package jtframe_mixgain_pkg;

    localparam int GAIN_W = 8;
    localparam logic [GAIN_W-1:0] UNITY_GAIN = 8'h10;

    localparam logic [1:0] LIM_NORMAL  = 2'd0;
    localparam logic [1:0] LIM_HOLD    = 2'd1;
    localparam logic [1:0] LIM_RELEASE = 2'd2;

    // Moves cur one LSB toward tgt; never overshoots, so 8'h00/8'hFF are never crossed
    function automatic logic [GAIN_W-1:0] step_toward(
        input logic [GAIN_W-1:0] cur,
        input logic [GAIN_W-1:0] tgt
    );
        if (cur < tgt)
            return cur + GAIN_W'(1);
        else if (cur > tgt)
            return cur - GAIN_W'(1);
        else
            return cur;
    endfunction

endpackage

// File: rtl/jtframe_mixgain_lim.sv
// Peak-driven limiter: raises the attenuation shift on each mixer overflow and
// releases it one step after HOLD quiet cen ticks.
module jtframe_mixgain_lim
    import jtframe_mixgain_pkg::*;
#(
    parameter int HOLD   = 1024,
    parameter int MAXATT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       peak,
    output logic [2:0] att
);

    localparam int HW = $clog2(HOLD + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD);
    localparam logic [2:0]    ATT_MAX   = 3'(MAXATT);

    logic [1:0]    st_reg, st_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic [2:0]    att_reg, att_next;
    logic [2:0]    att_inc;

    always_comb begin
        att_inc   = (att_reg < ATT_MAX) ? att_reg + 3'd1 : ATT_MAX;
        st_next   = st_reg;
        hold_next = hold_reg;
        att_next  = att_reg;
        // A peak always wins: bump attenuation and restart the hold window
        if (peak) begin
            att_next  = att_inc;
            hold_next = HOLD_LOAD;
            st_next   = LIM_HOLD;
        end else begin
            case (st_reg)
                LIM_HOLD: begin
                    hold_next = hold_reg - HW'(1);
                    if (hold_reg == HW'(1))
                        st_next = LIM_RELEASE;
                end
                LIM_RELEASE: begin
                    if (att_reg != 3'd0) begin
                        att_next  = att_reg - 3'd1;
                        hold_next = HOLD_LOAD;
                        st_next   = LIM_HOLD;
                    end else begin
                        st_next = LIM_NORMAL;
                    end
                end
                default: st_next = LIM_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_reg   <= LIM_NORMAL;
            hold_reg <= '0;
            att_reg  <= 3'd0;
        end else if (cen) begin
            st_reg   <= st_next;
            hold_reg <= hold_next;
            att_reg  <= att_next;
        end
    end

    assign att = att_reg;

endmodule

// File: rtl/jtframe_mixgain_ctl.sv
// Four-channel gain controller: ramps live gains toward (muted/limited) targets,
// one channel per step tick. Define JTFRAME_MIXGAIN_LIMIT_EN to build the peak limiter.
module jtframe_mixgain_ctl
    import jtframe_mixgain_pkg::*;
#(
    parameter int STEPDIV = 8,
    parameter int HOLD    = 1024,
    parameter int MAXATT  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cfg_we,
    input  logic [1:0] cfg_ch,
    input  logic [7:0] cfg_gain,
    input  logic       mute,
    input  logic       peak,
    output logic [7:0] gain0,
    output logic [7:0] gain1,
    output logic [7:0] gain2,
    output logic [7:0] gain3,
    output logic [2:0] att,
    output logic       busy
);

    localparam int DW = (STEPDIV > 1) ? $clog2(STEPDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(STEPDIV - 1);

    logic [GAIN_W-1:0] tgt_reg  [4];
    logic [GAIN_W-1:0] gain_reg [4];
    logic [GAIN_W-1:0] eff      [4];
    logic [3:0]        diff;
    logic [DW-1:0]     div_reg;
    logic [1:0]        ptr_reg;
    logic              step_tick;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            assign eff[gi]  = mute ? '0 : (tgt_reg[gi] >> att);
            assign diff[gi] = (gain_reg[gi] != eff[gi]);
        end
    endgenerate

    assign step_tick = cen && (div_reg == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= '0;
            ptr_reg <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                tgt_reg[i]  <= UNITY_GAIN;
                gain_reg[i] <= '0;
            end
        end else begin
            if (cen) begin
                div_reg <= step_tick ? '0 : div_reg + DW'(1);
                if (step_tick)
                    ptr_reg <= ptr_reg + 2'd1;
            end
            // Target writes ignore cen; a step this cycle still sees the old target
            for (int i = 0; i < 4; i++) begin
                if (cfg_we && cfg_ch == 2'(i))
                    tgt_reg[i] <= cfg_gain;
                if (step_tick && ptr_reg == 2'(i))
                    gain_reg[i] <= step_toward(gain_reg[i], eff[i]);
            end
        end
    end

`ifdef JTFRAME_MIXGAIN_LIMIT_EN
    jtframe_mixgain_lim #(
        .HOLD   (HOLD),
        .MAXATT (MAXATT)
    ) u_lim (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .peak (peak),
        .att  (att)
    );
`else
    localparam int unused_lim_params = HOLD + MAXATT;
    logic unused_peak;
    assign unused_peak = peak;
    assign att = 3'd0;
`endif

    assign gain0 = gain_reg[0];
    assign gain1 = gain_reg[1];
    assign gain2 = gain_reg[2];
    assign gain3 = gain_reg[3];
    assign busy  = |diff;

endmodule

// File: tb/tb_jtframe_mixgain_ctl.sv
// Scoreboard bench for jtframe_mixgain_ctl: the driver updates a cen-count based
// reference model and queues expected outputs; the monitor checks every cycle.
module tb_jtframe_mixgain_ctl;

    localparam int STEPDIV = 2;
    localparam int HOLD    = 16;
    localparam int MAXATT  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [7:0] cfg_gain = 8'd0;
    logic       mute = 1'b0;
    logic       peak = 1'b0;
    logic [7:0] gain0, gain1, gain2, gain3;
    logic [2:0] att;
    logic       busy;

    always #5 clk = ~clk;

    jtframe_mixgain_ctl #(
        .STEPDIV (STEPDIV),
        .HOLD    (HOLD),
        .MAXATT  (MAXATT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_gain (cfg_gain),
        .mute     (mute),
        .peak     (peak),
        .gain0    (gain0),
        .gain1    (gain1),
        .gain2    (gain2),
        .gain3    (gain3),
        .att      (att),
        .busy     (busy)
    );

    typedef struct packed {
        logic [3:0][7:0] g;
        logic [2:0]      a;
        logic            b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: ramp position derived from the number of cen ticks since reset
    int m_tgt[4];
    int m_gain[4];
    int m_att;
    int m_cen_cnt;
    int m_quiet;
    bit m_armed;

    function automatic int m_eff(int c);
        return mute ? 0 : (m_tgt[c] >> m_att);
    endfunction

    task automatic model_cycle();
        exp_t e;
        int   c;
        int   tv;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_tgt[i]  = 16;
                m_gain[i] = 0;
            end
            m_att = 0; m_cen_cnt = 0; m_quiet = 0; m_armed = 0;
        end else begin
            if (cen) begin
                if (m_cen_cnt % STEPDIV == STEPDIV - 1) begin
                    c  = (m_cen_cnt / STEPDIV) % 4;
                    tv = m_eff(c);
                    if (m_gain[c] < tv) m_gain[c]++;
                    else if (m_gain[c] > tv) m_gain[c]--;
                end
                m_cen_cnt++;
`ifdef JTFRAME_MIXGAIN_LIMIT_EN
                if (peak) begin
                    if (m_att < MAXATT) m_att++;
                    m_armed = 1; m_quiet = 0;
                end else if (m_armed) begin
                    if (m_quiet == HOLD) begin
                        if (m_att > 0) begin m_att--; m_quiet = 0; end
                        else m_armed = 0;
                    end else begin
                        m_quiet++;
                    end
                end
`endif
            end
            if (cfg_we) m_tgt[cfg_ch] = int'(cfg_gain);
        end
        e.b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e.g[i] = 8'(m_gain[i]);
            if (m_gain[i] != m_eff(i)) e.b = 1'b1;
        end
        e.a = 3'(m_att);
        exp_q.push_back(e);
    endtask

    // Inputs are set on the falling edge; the model predicts the state after the next rising edge
    task automatic tick();
        model_cycle();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [7:0] g);
        cfg_we = 1'b1; cfg_ch = ch; cfg_gain = g;
        $display("cyc=%0d cfg write ch=%0d gain=%h", cyc, ch, g);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic print_summary();
        $display("test done: total=%0d bad=%0d", total, bad);
    endtask

    initial begin : monitor
        exp_t e;
        logic [3:0][7:0] got_g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got_g = {gain3, gain2, gain1, gain0};
                total++;
                if (got_g !== e.g) begin
                    bad++;
                    $display("FAIL gains t=%0t got=%h expected=%h", $time, got_g, e.g);
                end
                total++;
                if (att !== e.a) begin
                    bad++;
                    $display("FAIL att t=%0t got=%0d expected=%0d", $time, att, e.a);
                end
                total++;
                if (busy !== e.b) begin
                    bad++;
                    $display("FAIL busy t=%0t got=%b expected=%b", $time, busy, e.b);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        bad++;
        $display("FAIL timeout: bench did not complete in time");
        print_summary();
        $finish;
    end

    initial begin : driver
        int guard;
        @(negedge clk);
        rst = 1'b1;
        $display("cyc=%0d reset asserted", cyc);
        run(3);
        rst = 1'b0; cen = 1'b1;
        $display("cyc=%0d reset released, ramp to unity", cyc);
        run(140);

        write_cfg(2'd2, 8'h08);
        run(80);

        mute = 1'b1;
        $display("cyc=%0d mute on", cyc);
        run(150);
        mute = 1'b0;
        $display("cyc=%0d mute off", cyc);
        run(150);

        // Write the channel being stepped in the very same cycle
        guard = 0;
        while (m_cen_cnt % STEPDIV != STEPDIV - 1 && guard < 8) begin
            tick(); guard++;
        end
        write_cfg(2'((m_cen_cnt / STEPDIV) % 4), 8'h30);
        run(300);

        write_cfg(2'd0, 8'h10);
        run(300);
        for (int p = 0; p < 3; p++) begin
            peak = 1'b1;
            $display("cyc=%0d peak pulse %0d", cyc, p);
            tick();
            peak = 1'b0;
            run(3);
        end
        run(120);
        for (int p = 0; p < 5; p++) begin
            peak = 1'b1;
            $display("cyc=%0d peak pulse at limit %0d", cyc, p);
            tick();
        end
        peak = 1'b0;
        run(100);

        write_cfg(2'd1, 8'hFF);
        run(40);
        rst = 1'b1;
        $display("cyc=%0d reset mid-ramp", cyc);
        tick();
        rst = 1'b0;
        run(40);

        for (int k = 0; k < 2500; k++) begin
            cen  = ($urandom_range(0, 3) != 0);
            peak = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 199) == 0) begin
                mute = ~mute;
                $display("cyc=%0d mute=%b", cyc, mute);
            end
            if ($urandom_range(0, 24) == 0) begin
                write_cfg(2'($urandom_range(0, 3)), 8'($urandom_range(0, 48)));
            end else begin
                tick();
            end
        end
        cen = 1'b1; peak = 1'b0; mute = 1'b0;
        run(20);

        repeat (2) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
        end
        print_summary();
        $finish;
    end

endmodule

// File: doc/jtframe_mixgain_ctl.md
Name: jtframe_mixgain_ctl

Overview:
Gain controller for the four-channel 4.4-gain audio mixer. Holds per-channel target gains written by the CPU/core and ramps the live gain outputs toward them one LSB per step, round-robin, to avoid zipper noise. An optional peak-driven limiter feeds back from the mixer's peak output and attenuates all gains by right-shifts, with hold/release timing. Sits between core configuration logic and the mixer gain inputs, same clk/cen domain.

Parameters:
STEPDIV, 8, cen ticks per ramp step (>=1)
HOLD, 1024, cen ticks without peak before one limiter release step
MAXATT, 3, maximum limiter attenuation (right-shift amount, 0..7)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
cen  in  1  audio sample clock enable; all state advances only when cen=1, except cfg writes
cfg_we  in  1  write target gain (any cycle, cen-independent)
cfg_ch  in  2  channel index for write
cfg_gain  in  8  target gain, 4.4 unsigned
mute  in  1  force all effective targets to 0 (ramped, not instant)
peak  in  1  overflow flag from mixer
gain0..gain3  out  8 each  live gains to mixer
att  out  3  current limiter shift
busy  out  1  1 while any live gain differs from its effective target

Behaviour:
- Reset values: tgt[i]=8'h10 (unity), gain[i]=0, att=0, hold counter=0, step divider=0, channel pointer ptr=0, busy=1 after first cycle out of reset (gains 0 vs 8'h10), limiter state NORMAL.
- Effective target eff[i] = mute ? 0 : (tgt[i] >> att).
- cfg_we: tgt[cfg_ch] <= cfg_gain next clk edge. A step on the same channel in the same cycle uses the old tgt; new value visible from the following cycle.
- Step divider counts cen pulses 0..STEPDIV-1; on wrap (step tick) channel ptr is processed: gain[ptr] +1 if below eff[ptr], -1 if above, unchanged if equal; ptr then increments mod 4. One channel changes per step tick; full 0->8'hFF ramp = 255*4*STEPDIV cen ticks.
- Gain never wraps: saturates at eff; 8'h00 and 8'hFF are never crossed.
- busy: combinational OR of (gain[i]!=eff[i]).
- Limiter FSM (cen-qualified): NORMAL: peak -> att<=min(att+1,MAXATT), hold<=HOLD, go HOLD. HOLD: peak -> att+1 (saturate), hold reload; no peak -> hold-1; hold reaches 0 -> RELEASE. RELEASE: if att>0 then att-1, hold<=HOLD, go HOLD (peak in this cycle wins: att+1, stay HOLD); if att==0 go NORMAL.
- att change alters eff immediately; live gains follow via the ramp (attack is not instant).
- Reset mid-ramp or mid-hold: everything returns to reset values on the next edge; no partial steps.
- cen=0: no ramp, limiter, divider or ptr change; cfg writes still accepted.

Optional Feature:
JTFRAME_MIXGAIN_LIMIT_EN: defined -> limiter FSM, hold counter and att as above. Undefined -> att tied to 0, peak ignored, FSM and hold counter not synthesized; ramp/config behaviour identical.

Decomposition:
- Package jtframe_mixgain_pkg: limiter state encoding (NORMAL, HOLD, RELEASE), UNITY_GAIN=8'h10, gain width constant 8.
- One sub-module: jtframe_mixgain_lim (limiter FSM + hold counter, inputs peak/cen, output att), instantiated only under JTFRAME_MIXGAIN_LIMIT_EN.

Test Plan:
- Reset release, STEPDIV=1, cen=1 constant -> each gain reaches 8'h10 after 16*4=64 cen ticks; busy drops to 0 on that cycle; ptr order 0,1,2,3.
- Write cfg_ch=2, cfg_gain=8'h08 with gains settled at 8'h10 -> gain2 decrements 1 every 4 step ticks to 8'h08, others stay 8'h10.
- mute=1 with all gains 8'h10 -> all ramp to 0, busy=1 until then; mute=0 -> back to 8'h10.
- cfg_we on ptr's channel in step-tick cycle -> that step uses old target; next visit uses new.
- LIMIT_EN, HOLD=16: three peak pulses -> att=3, eff=8'h02 for unity targets; then 16 quiet cen ticks per release -> att 2,1,0, state back to NORMAL after 48+ ticks; peak at MAXATT keeps att=3.
- LIMIT_EN undefined: peak pulses -> att stays 0, gains unchanged.
